// File: rtl/car_hyper_cfg_seq_pkg.sv
// Default reg-bus types and sequencer state encoding for the HyperBus config sequencer.
// No logic, no latency.
// No backpressure: types only.
package car_hyper_cfg_seq_pkg;

   localparam int unsigned CfgAddrWidth = 48;
   localparam int unsigned CfgDataWidth = 32;
   localparam int unsigned CfgStrbWidth = CfgDataWidth / 8;

   // Default reg-bus request: the real Carfield types are passed in as type parameters.
   typedef struct packed {
      logic [CfgAddrWidth-1:0] addr;
      logic                    write;
      logic [CfgDataWidth-1:0] wdata;
      logic [CfgStrbWidth-1:0] wstrb;
      logic                    valid;
   } cfg_reg_req_t;

   // Default reg-bus response.
   typedef struct packed {
      logic [CfgDataWidth-1:0] rdata;
      logic                    error;
      logic                    ready;
   } cfg_reg_rsp_t;

   // Sequencer states: startup wait, table write, then pass-through with a result flag.
   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } seq_state_e;

   // The slave port is only connected through once the table has been handled.
   function automatic logic is_pass_thru(input seq_state_e st);
      return (st == ST_DONE) || (st == ST_ERROR);
   endfunction

endpackage

// File: rtl/car_hyper_cfg_seq.sv
// Boot-time HyperBus register initialiser that owns the config port, then hands it to the external reg slave.
// Init writes issue back-to-back (one per cycle with ready=1); pass-through adds zero latency.
// Slave is held off (ready=0) until the table is done; each init write waits at most TimeoutCycles for ready.
module car_hyper_cfg_seq
   import car_hyper_cfg_seq_pkg::*;
#(
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned NumInit       = 4,
   parameter logic [NumInit-1:0][AddrWidth-1:0] InitAddr = '0,
   parameter logic [NumInit-1:0][DataWidth-1:0] InitData = '0,
   parameter int unsigned StartupCycles = 60000,
   parameter int unsigned TimeoutCycles = 1024,
   parameter type         reg_req_t     = cfg_reg_req_t,
   parameter type         reg_rsp_t     = cfg_reg_rsp_t,
   localparam int unsigned IdxW         = (NumInit > 1) ? $clog2(NumInit) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            reinit_i,
   input  reg_req_t        slv_req_i,
   output reg_rsp_t        slv_rsp_o,
   output reg_req_t        mst_req_o,
   input  reg_rsp_t        mst_rsp_i,
   output logic            busy_o,
   output logic            init_done_o,
   output logic            init_err_o,
   output logic [IdxW-1:0] err_idx_o
);

   localparam int unsigned WaitW = (StartupCycles > 0) ? $clog2(StartupCycles + 1) : 1;
   localparam int unsigned TmoW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

   // Terminal counts; zero startup means the first WAIT cycle is already the last one.
   localparam logic [WaitW-1:0] WaitLast = WaitW'((StartupCycles == 0) ? 0 : StartupCycles - 1);
   localparam logic [TmoW-1:0]  TmoLast  = TmoW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumInit - 1);

   seq_state_e       state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q;
   logic [TmoW-1:0]  tmo_cnt_q;
   logic [IdxW-1:0]  idx_q;
   logic [IdxW-1:0]  err_idx_q;
   logic             reinit_pend_q;

   logic wait_last;
   logic tmo_last;
   logic idx_last;
   logic pass_thru;
   logic in_write;
   logic write_ok;
   logic write_fail;
   logic slv_quiet;
   logic reinit_take;

   assign wait_last  = (wait_cnt_q == WaitLast);
   assign tmo_last   = (tmo_cnt_q == TmoLast);
   assign idx_last   = (idx_q == IdxLast);
   assign pass_thru  = is_pass_thru(state_q);
   assign in_write   = (state_q == ST_WRITE);
   assign write_ok   = in_write && mst_rsp_i.ready && !mst_rsp_i.error;
   assign write_fail = in_write && ((mst_rsp_i.ready && mst_rsp_i.error) ||
                                    (!mst_rsp_i.ready && tmo_last));

   // A restart must never cut an in-flight slave transfer: only when idle or completing now.
   assign slv_quiet   = !slv_req_i.valid || mst_rsp_i.ready;
   assign reinit_take = pass_thru && (reinit_i || reinit_pend_q) && slv_quiet;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: startup wait, table walk, then park in DONE/ERROR until a restart is accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT: begin
            if (wait_last) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (mst_rsp_i.ready) begin
               if (mst_rsp_i.error) state_d = ST_ERROR;
               else if (idx_last)   state_d = ST_DONE;
            end else if (tmo_last) begin
               state_d = ST_ERROR;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (reinit_take) state_d = ST_WRITE;
         end
         default: state_d = ST_WAIT;
      endcase
   end

   // Outputs: drive the current table entry while writing, otherwise wire the slave straight through.
   always_comb begin
      mst_req_o   = '0;
      slv_rsp_o   = '0;
      busy_o      = !pass_thru;
      init_done_o = (state_q == ST_DONE);
      init_err_o  = (state_q == ST_ERROR);
      err_idx_o   = err_idx_q;
      case (state_q)
         ST_WRITE: begin
            mst_req_o.valid = 1'b1;
            mst_req_o.write = 1'b1;
            mst_req_o.addr  = InitAddr[idx_q];
            mst_req_o.wdata = InitData[idx_q];
            mst_req_o.wstrb = '1;
         end
         ST_DONE, ST_ERROR: begin
            mst_req_o = slv_req_i;
            slv_rsp_o = mst_rsp_i;
         end
         default: ;
      endcase
   end

   // Counters, table index, failing index and the latched restart request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
         idx_q         <= '0;
         err_idx_q     <= '0;
         reinit_pend_q <= 1'b0;
      end else begin
         if ((state_q == ST_WAIT) && !wait_last) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end

         // Per-write stall budget restarts on every handshake and outside WRITE.
         if (in_write && !mst_rsp_i.ready && !tmo_last) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end else begin
            tmo_cnt_q <= '0;
         end

         if (reinit_take) begin
            idx_q <= '0;
         end else if (write_ok && !idx_last) begin
            idx_q <= idx_q + 1'b1;
         end

         if (reinit_take) begin
            err_idx_q <= '0;
         end else if (write_fail) begin
            err_idx_q <= idx_q;
         end

         // Restarts requested while the sequence itself is running are dropped.
         reinit_pend_q <= pass_thru && !reinit_take && (reinit_i || reinit_pend_q);
      end
   end

endmodule

// File: tb/tb_car_hyper_cfg_seq.sv
module tb_car_hyper_cfg_seq;
   import car_hyper_cfg_seq_pkg::*;

   localparam int unsigned NumInit       = 4;
   localparam int unsigned StartupCycles = 16;
   localparam int unsigned TimeoutCycles = 8;

   localparam logic [NumInit-1:0][47:0] InitAddr = {
      48'h0000_0000_100C, 48'h0000_0000_1008, 48'h0000_0000_1004, 48'h0000_0000_1000};
   localparam logic [NumInit-1:0][31:0] InitData = {
      32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};

   // Expected table contents, written out independently of the parameter packing.
   logic [47:0] exp_addr [4] = '{48'h1000, 48'h1004, 48'h1008, 48'h100C};
   logic [31:0] exp_data [4] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         reinit = 1'b0;
   cfg_reg_req_t slv_req, mst_req;
   cfg_reg_rsp_t slv_rsp, mst_rsp;
   logic         busy, init_done, init_err;
   logic [1:0]   err_idx;

   int n_chk = 0;
   int n_err = 0;

   car_hyper_cfg_seq #(
      .AddrWidth     (48),
      .DataWidth     (32),
      .NumInit       (NumInit),
      .InitAddr      (InitAddr),
      .InitData      (InitData),
      .StartupCycles (StartupCycles),
      .TimeoutCycles (TimeoutCycles),
      .reg_req_t     (cfg_reg_req_t),
      .reg_rsp_t     (cfg_reg_rsp_t)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .reinit_i    (reinit),
      .slv_req_i   (slv_req),
      .slv_rsp_o   (slv_rsp),
      .mst_req_o   (mst_req),
      .mst_rsp_i   (mst_rsp),
      .busy_o      (busy),
      .init_done_o (init_done),
      .init_err_o  (init_err),
      .err_idx_o   (err_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        s_vld;
      logic        s_wr;
      logic [47:0] s_addr;
      logic [31:0] s_wdata;
      logic        m_rdy;
      logic        m_err;
      logic [31:0] m_rdata;
      logic        e_m_vld;
      logic        e_m_wr;
      logic [47:0] e_m_addr;
      logic [31:0] e_m_wdata;
      logic        e_s_rdy;
      logic        e_s_err;
      logic [31:0] e_s_rdata;
   } pt_vec_t;

   pt_vec_t pt_vec [4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      slv_req = '0;
      mst_rsp = '0;
      reinit  = 1'b0;
   endtask

   // Hold reset over two edges, check reset outputs, release just after an edge (next edge = cycle 1).
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mst_req_zero", 64'(mst_req == '0), 64'd1);
      chk("rst_slv_rsp_zero", 64'(slv_rsp == '0), 64'd1);
      chk("rst_busy",         64'(busy),          64'd1);
      chk("rst_done",         64'(init_done),     64'd0);
      chk("rst_err",          64'(init_err),      64'd0);
      chk("rst_err_idx",      64'(err_idx),       64'd0);
      rst_n = 1'b1;
   endtask

   task automatic check_write(input int i);
      chk("wr_vld",   64'(mst_req.valid), 64'd1);
      chk("wr_write", 64'(mst_req.write), 64'd1);
      chk("wr_addr",  64'(mst_req.addr),  64'(exp_addr[i]));
      chk("wr_data",  64'(mst_req.wdata), 64'(exp_data[i]));
      chk("wr_strb",  64'(mst_req.wstrb), 64'hF);
      chk("wr_slv_blocked", 64'(slv_rsp.ready), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen3;
      logic finished;

      pt_vec[0] = '{"pt_idle",     1'b0, 1'b0, 48'h0,    32'h0,
                    1'b0, 1'b0, 32'h1234_5678,
                    1'b0, 1'b0, 48'h0,    32'h0,         1'b0, 1'b0, 32'h1234_5678};
      pt_vec[1] = '{"pt_write",    1'b1, 1'b1, 48'h3000, 32'hDEAD_BEEF,
                    1'b1, 1'b0, 32'h0,
                    1'b1, 1'b1, 48'h3000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
      pt_vec[2] = '{"pt_read_err", 1'b1, 1'b0, 48'h3010, 32'h0,
                    1'b1, 1'b1, 32'h0000_00EE,
                    1'b1, 1'b0, 48'h3010, 32'h0,         1'b1, 1'b1, 32'h0000_00EE};
      pt_vec[3] = '{"pt_stall",    1'b1, 1'b0, 48'h3020, 32'h0,
                    1'b0, 1'b0, 32'h0000_7777,
                    1'b1, 1'b0, 48'h3020, 32'h0,         1'b0, 1'b0, 32'h0000_7777};

      // Normal init, with a slave read already waiting during the startup period.
      idle_inputs();
      slv_req.valid = 1'b1;
      slv_req.addr  = 48'h2000;
      mst_rsp.ready = 1'b1;
      mst_rsp.rdata = 32'hCAFE_0001;
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e < 16) begin
            chk("wait_mst_vld", 64'(mst_req.valid), 64'd0);
            chk("wait_slv_rdy", 64'(slv_rsp.ready), 64'd0);
            chk("wait_slv_rdata", 64'(slv_rsp.rdata), 64'd0);
            chk("wait_busy", 64'(busy), 64'd1);
         end else if (e < 20) begin
            check_write(e - 16);
            chk("write_done_low", 64'(init_done), 64'd0);
         end else begin
            chk("init_done",   64'(init_done),     64'd1);
            chk("done_busy",   64'(busy),          64'd0);
            chk("slv_rd_rdy",  64'(slv_rsp.ready), 64'd1);
            chk("slv_rd_data", 64'(slv_rsp.rdata), 64'hCAFE_0001);
            chk("slv_rd_addr", 64'(mst_req.addr),  64'h2000);
         end
      end
      slv_req = '0;

      // Pass-through vectors while DONE.
      for (int i = 0; i < 4; i++) begin
         slv_req.valid = pt_vec[i].s_vld;
         slv_req.write = pt_vec[i].s_wr;
         slv_req.addr  = pt_vec[i].s_addr;
         slv_req.wdata = pt_vec[i].s_wdata;
         slv_req.wstrb = 4'hF;
         mst_rsp.ready = pt_vec[i].m_rdy;
         mst_rsp.error = pt_vec[i].m_err;
         mst_rsp.rdata = pt_vec[i].m_rdata;
         #1;
         chk({pt_vec[i].nm, "_m_vld"},   64'(mst_req.valid), 64'(pt_vec[i].e_m_vld));
         chk({pt_vec[i].nm, "_m_wr"},    64'(mst_req.write), 64'(pt_vec[i].e_m_wr));
         chk({pt_vec[i].nm, "_m_addr"},  64'(mst_req.addr),  64'(pt_vec[i].e_m_addr));
         chk({pt_vec[i].nm, "_m_wdata"}, 64'(mst_req.wdata), 64'(pt_vec[i].e_m_wdata));
         chk({pt_vec[i].nm, "_s_rdy"},   64'(slv_rsp.ready), 64'(pt_vec[i].e_s_rdy));
         chk({pt_vec[i].nm, "_s_err"},   64'(slv_rsp.error), 64'(pt_vec[i].e_s_err));
         chk({pt_vec[i].nm, "_s_rdata"}, 64'(slv_rsp.rdata), 64'(pt_vec[i].e_s_rdata));
         tick();
         chk({pt_vec[i].nm, "_still_done"}, 64'(init_done), 64'd1);
      end

      // Error response on entry 2: entry 3 must never be issued.
      idle_inputs();
      mst_rsp.ready = 1'b1;
      do_reset();
      seen3 = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < 40 && !finished; c++) begin
         tick();
         if (busy && mst_req.valid && (mst_req.addr == exp_addr[3])) seen3 = 1'b1;
         mst_rsp.error = busy && mst_req.valid && (mst_req.addr == exp_addr[2]);
         if (init_err || init_done) finished = 1'b1;
      end
      chk("err_finished",  64'(finished),  64'd1);
      chk("err_flag",      64'(init_err),  64'd1);
      chk("err_done_low",  64'(init_done), 64'd0);
      chk("err_idx2",      64'(err_idx),   64'd2);
      chk("err_no_entry3", 64'(seen3),     64'd0);
      chk("err_busy",      64'(busy),      64'd0);
      slv_req.valid = 1'b1;
      slv_req.addr  = 48'h3004;
      mst_rsp.error = 1'b0;
      mst_rsp.rdata = 32'h5555_AAAA;
      #1;
      chk("err_pt_vld",   64'(mst_req.valid), 64'd1);
      chk("err_pt_addr",  64'(mst_req.addr),  64'h3004);
      chk("err_pt_rdy",   64'(slv_rsp.ready), 64'd1);
      chk("err_pt_rdata", 64'(slv_rsp.rdata), 64'h5555_AAAA);

      // Timeout on entry 0: eight stalled cycles then ERROR with valid dropped.
      idle_inputs();
      do_reset();
      repeat (16) tick();
      chk("tmo_first_vld", 64'(mst_req.valid), 64'd1);
      chk("tmo_first_addr", 64'(mst_req.addr), 64'h1000);
      for (int e = 17; e <= 23; e++) begin
         tick();
         chk("tmo_hold_vld", 64'(mst_req.valid), 64'd1);
         chk("tmo_no_err_yet", 64'(init_err), 64'd0);
      end
      tick();
      chk("tmo_err",     64'(init_err),      64'd1);
      chk("tmo_vld_low", 64'(mst_req.valid), 64'd0);
      chk("tmo_err_idx", 64'(err_idx),       64'd0);
      chk("tmo_busy",    64'(busy),          64'd0);

      // Restart requested while a slave read is stalled for three cycles.
      slv_req.valid = 1'b1;
      slv_req.addr  = 48'h3008;
      mst_rsp.ready = 1'b0;
      mst_rsp.rdata = 32'h0BAD_F00D;
      reinit = 1'b1;
      #1;
      chk("ri_pt_vld", 64'(mst_req.valid), 64'd1);
      chk("ri_stall_rdy", 64'(slv_rsp.ready), 64'd0);
      tick();
      reinit = 1'b0;
      chk("ri_pending_err", 64'(init_err), 64'd1);
      tick();
      chk("ri_pending_busy", 64'(busy), 64'd0);
      tick();
      chk("ri_pending_busy2", 64'(busy), 64'd0);
      mst_rsp.ready = 1'b1;
      #1;
      chk("ri_slv_rdy",   64'(slv_rsp.ready), 64'd1);
      chk("ri_slv_rdata", 64'(slv_rsp.rdata), 64'h0BAD_F00D);
      tick();
      slv_req.valid = 1'b0;
      #1;
      chk("ri_busy",     64'(busy),     64'd1);
      chk("ri_err_clr",  64'(init_err), 64'd0);
      chk("ri_idx_clr",  64'(err_idx),  64'd0);
      check_write(0);
      reinit = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         reinit = 1'b0;
         check_write(i);
      end
      tick();
      chk("ri_done", 64'(init_done), 64'd1);
      repeat (2) tick();
      chk("ri_ignored_in_write", 64'(init_done), 64'd1);
      chk("ri_ignored_busy", 64'(busy), 64'd0);

      // Asynchronous reset during entry 1, then a full rerun.
      idle_inputs();
      mst_rsp.ready = 1'b1;
      do_reset();
      repeat (17) tick();
      check_write(1);
      slv_req.valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("arst_mst_vld", 64'(mst_req.valid), 64'd0);
      chk("arst_mst_zero", 64'(mst_req == '0), 64'd1);
      chk("arst_busy",    64'(busy),          64'd1);
      chk("arst_done",    64'(init_done),     64'd0);
      chk("arst_slv_rdy", 64'(slv_rsp.ready), 64'd0);
      slv_req.valid = 1'b0;
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 15) chk("rerun_wait_vld", 64'(mst_req.valid), 64'd0);
         if (e >= 16 && e <= 19) check_write(e - 16);
         if (e == 20) chk("rerun_done", 64'(init_done), 64'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
